// File: rtl/bram_seq_pkg.sv
// Shared definitions for the BRAM port sequencer: state encoding, error
// counter width and the write-data pattern generator.
// The optional inverted pass is enabled by defining BRAM_SEQ_INV_PASS_EN.
package bram_seq_pkg;

  // Width of the saturating mismatch counter.
  localparam int unsigned ErrCountWidth = 16;

  // Working width of the pattern arithmetic; callers truncate to their data width.
  localparam int unsigned PatWidth = 64;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StWrite = 3'd1,
    StRead  = 3'd2,
    StDrain = 3'd3,
    StFin   = 3'd4
`ifdef BRAM_SEQ_INV_PASS_EN
    ,
    StWriteInv = 3'd5,
    StReadInv  = 3'd6
`endif
  } seq_state_e;

  // Pattern for address a: seed + zero-extended a. Only the low data-width bits are used,
  // so truncating the sum gives the required modulo behaviour.
  function automatic logic [PatWidth-1:0] pattern(input logic [PatWidth-1:0] seed,
                                                  input logic [PatWidth-1:0] addr);
    return seed + addr;
  endfunction

endpackage

// File: rtl/bram_seq_checker.sv
// Read-back checker: one-stage tracker of issued reads, data comparator,
// saturating mismatch counter and first-error address latch.
// Supports DATA_WIDTH up to 63 bits.
module bram_seq_checker
  import bram_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     clear_i,
  input  logic                     rd_issued_i,
  input  logic [ADDR_WIDTH-1:0]    rd_addr_i,
  input  logic                     rd_inv_i,
  input  logic [DATA_WIDTH-1:0]    seed_i,
  input  logic [DATA_WIDTH-1:0]    rd_data_i,
  input  logic                     rd_valid_i,
  output logic [ErrCountWidth-1:0] err_count_o,
  output logic [ADDR_WIDTH-1:0]    first_err_addr_o,
  output logic                     err_fire_o
);

  logic                     pend_q;
  logic [ADDR_WIDTH-1:0]    pend_addr_q;
  logic                     pend_inv_q;
  logic [ErrCountWidth-1:0] err_q;
  logic [ADDR_WIDTH-1:0]    first_q;

  logic [PatWidth-1:0]   exp_full;
  logic [DATA_WIDTH-1:0] exp_data;
  logic                  unused_exp;

  // Expected data for the outstanding read and the mismatch decision.
  always_comb begin
    exp_full = pattern(PatWidth'(seed_i), PatWidth'(pend_addr_q));
    exp_data = exp_full[DATA_WIDTH-1:0];
    if (pend_inv_q) begin
      exp_data = ~exp_data;
    end
    // A missing valid counts the same as wrong data; valid with nothing pending is ignored.
    err_fire_o = pend_q && (!rd_valid_i || (rd_data_i != exp_data));
  end

  assign unused_exp = ^exp_full[PatWidth-1:DATA_WIDTH];

  // Tracker capture, saturating count and first-error latch.
  always_ff @(posedge CLK) begin
    if (RST || clear_i) begin
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      pend_inv_q  <= 1'b0;
      err_q       <= '0;
      first_q     <= '0;
    end else begin
      pend_q      <= rd_issued_i;
      pend_addr_q <= rd_addr_i;
      pend_inv_q  <= rd_inv_i;
      if (err_fire_o) begin
        if (err_q != '1) begin
          err_q <= err_q + 1'b1;
        end
        if (err_q == '0) begin
          first_q <= pend_addr_q;
        end
      end
    end
  end

  assign err_count_o      = err_q;
  assign first_err_addr_o = first_q;

endmodule

// File: rtl/bram_port_sequencer.sv
// BRAM port sequencer: writes a seeded pattern over the whole RAM, reads it
// back and reports mismatches. All outputs are registered; the port shows the
// access decoded from the current state one cycle later.
// Define BRAM_SEQ_INV_PASS_EN to add a second write/read pass using ~pattern.
// Supports DATA_WIDTH up to 63 bits.
module bram_port_sequencer
  import bram_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     START,
  input  logic [DATA_WIDTH-1:0]    SEED,
  output logic                     BUSY,
  output logic                     DONE,
  output logic                     PASS,
  output logic [ErrCountWidth-1:0] ERR_COUNT,
  output logic [ADDR_WIDTH-1:0]    FIRST_ERR_ADDR,
  output logic                     EN,
  output logic                     WE,
  output logic [ADDR_WIDTH-1:0]    ADDR,
  output logic [DATA_WIDTH-1:0]    DI,
  input  logic [DATA_WIDTH-1:0]    DO,
  input  logic                     DO_VALID
);

  seq_state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] seed_q, seed_d;
  logic                  en_q, en_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] di_q, di_d;
  logic                  inv_q, inv_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic                  clear;
  logic                  cnt_last;

  logic [PatWidth-1:0]   pat_full;
  logic [DATA_WIDTH-1:0] pat;
  logic                  unused_pat;

  logic [ErrCountWidth-1:0] err_count;
  logic [ADDR_WIDTH-1:0]    first_err_addr;
  logic                     err_fire;

  assign pat_full   = pattern(PatWidth'(seed_q), PatWidth'(cnt_q));
  assign pat        = pat_full[DATA_WIDTH-1:0];
  assign unused_pat = ^pat_full[PatWidth-1:DATA_WIDTH];
  assign cnt_last   = (cnt_q == '1);

  // Next-state and next-output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    seed_d  = seed_q;
    en_d    = 1'b0;
    we_d    = 1'b0;
    addr_d  = addr_q;
    di_d    = di_q;
    inv_d   = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    pass_d  = pass_q;
    clear   = 1'b0;

    case (state_q)
      StIdle: begin
        if (START) begin
          seed_d  = SEED;
          pass_d  = 1'b0;
          clear   = 1'b1;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = StWrite;
        end
      end
      StWrite: begin
        busy_d = 1'b1;
        en_d   = 1'b1;
        we_d   = 1'b1;
        addr_d = cnt_q;
        di_d   = pat;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_last) begin
          state_d = StRead;
        end
      end
      StRead: begin
        busy_d = 1'b1;
        en_d   = 1'b1;
        addr_d = cnt_q;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_last) begin
`ifdef BRAM_SEQ_INV_PASS_EN
          state_d = StWriteInv;
`else
          state_d = StDrain;
`endif
        end
      end
`ifdef BRAM_SEQ_INV_PASS_EN
      StWriteInv: begin
        busy_d = 1'b1;
        en_d   = 1'b1;
        we_d   = 1'b1;
        addr_d = cnt_q;
        di_d   = ~pat;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_last) begin
          state_d = StReadInv;
        end
      end
      StReadInv: begin
        busy_d = 1'b1;
        en_d   = 1'b1;
        inv_d  = 1'b1;
        addr_d = cnt_q;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_last) begin
          state_d = StDrain;
        end
      end
`endif
      StDrain: begin
        // Port goes idle while the checker consumes the final read.
        busy_d  = 1'b1;
        state_d = StFin;
      end
      StFin: begin
        done_d  = 1'b1;
        // The last read is judged in this same cycle, so include it.
        pass_d  = (err_count == '0) && !err_fire;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and registered-output update with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      seed_q  <= '0;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      di_q    <= '0;
      inv_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      seed_q  <= seed_d;
      en_q    <= en_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      di_q    <= di_d;
      inv_q   <= inv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  bram_seq_checker #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_checker (
    .CLK              (CLK),
    .RST              (RST),
    .clear_i          (clear),
    .rd_issued_i      (en_q & ~we_q),
    .rd_addr_i        (addr_q),
    .rd_inv_i         (inv_q),
    .seed_i           (seed_q),
    .rd_data_i        (DO),
    .rd_valid_i       (DO_VALID),
    .err_count_o      (err_count),
    .first_err_addr_o (first_err_addr),
    .err_fire_o       (err_fire)
  );

  assign EN             = en_q;
  assign WE             = we_q;
  assign ADDR           = addr_q;
  assign DI             = di_q;
  assign BUSY           = busy_q;
  assign DONE           = done_q;
  assign PASS           = pass_q;
  assign ERR_COUNT      = err_count;
  assign FIRST_ERR_ADDR = first_err_addr;

endmodule

// File: doc/bram_port_sequencer.md
BRAM_PORT_SEQUENCER -- requirements
Module: bram_port_sequencer

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 32, RAM word width; ADDR_WIDTH, default 10, RAM address width (depth 2**ADDR_WIDTH).
REQ-002 Ports SHALL be:
- CLK  in  1  sole clock; all logic on its rising edge.
- RST  in  1  reset; synchronous, active-high.
- START  in  1  run request; sampled only in IDLE.
- SEED  in  DATA_WIDTH  pattern seed; captured on an accepted START.
- BUSY  out  1  high from the cycle after START acceptance until DONE.
- DONE  out  1  one-cycle pulse at end of run.
- PASS  out  1  valid with DONE, held until the next START; high iff ERR_COUNT==0.
- ERR_COUNT  out  16  mismatch count, saturating at 16'hFFFF.
- FIRST_ERR_ADDR  out  ADDR_WIDTH  address of first mismatch; 0 if none.
- EN, WE  out  1  RAM port enable / write enable.
- ADDR  out  ADDR_WIDTH  RAM port address.
- DI  out  DATA_WIDTH  RAM write data.
- DO  in  DATA_WIDTH  RAM read data.
- DO_VALID  in  1  RAM read-data valid; one cycle after a read (EN=1, WE=0).
REQ-003 Clock is CLK, reset is RST; one clock domain; reset is synchronous and active-high.

Function
REQ-004 The block SHALL be the initiator for one port of a one-cycle-latency BRAM; all outputs SHALL be registered.
REQ-005 States SHALL be IDLE, WRITE, READ, DRAIN, FIN.
REQ-006 IDLE: EN=WE=0; START=1 SHALL capture SEED, clear ERR_COUNT/FIRST_ERR_ADDR/PASS, zero the address counter, go to WRITE.
REQ-007 WRITE: each cycle EN=1, WE=1, ADDR=a, DI=pattern(a); a SHALL increment from 0 to 2**ADDR_WIDTH-1, then wrap to 0 and go to READ.
REQ-008 pattern(a) SHALL be (SEED + zero-extended a) mod 2**DATA_WIDTH.
REQ-009 READ: each cycle EN=1, WE=0, ADDR=a over the full range once, then go to DRAIN.
REQ-010 A one-stage tracker SHALL record (read issued, ADDR) each cycle; the next cycle, if a read was issued, DO_VALID=1 and DO!=pattern(addr), or DO_VALID=0, SHALL count one error.
REQ-011 DO_VALID=1 with no outstanding read SHALL be ignored.
REQ-012 The first counted error SHALL load FIRST_ERR_ADDR; later errors SHALL NOT change it.
REQ-013 DRAIN: EN=0, one cycle, checks the last read, then go to FIN.
REQ-014 FIN: DONE=1 and PASS valid for one cycle, then IDLE; BUSY=0 in FIN.
REQ-015 Timing: START sampled at edge 0 SHALL put the first write on the RAM port after edge 1 and raise DONE after edge 2*2**ADDR_WIDTH+2 (single-pass build).
REQ-016 START outside IDLE SHALL be ignored; START held high in FIN SHALL be accepted on return to IDLE.

Reset
REQ-017 RST=1 at an edge SHALL force IDLE, EN=WE=0, ADDR=0, DI=0, BUSY=DONE=PASS=0, ERR_COUNT=0, FIRST_ERR_ADDR=0, tracker cleared, whatever the state.
REQ-018 Reset mid-run SHALL abandon the run with no DONE pulse; late DO_VALID SHALL be ignored.

Configuration
REQ-019 Macro BRAM_SEQ_INV_PASS_EN defined: after READ, add states WRITE_INV and READ_INV, using ~pattern(a), checked the same way, before DRAIN; DONE then comes after edge 4*2**ADDR_WIDTH+2.
REQ-020 Macro undefined: states WRITE_INV and READ_INV are absent; single pass only.

Structure
REQ-021 A shared package bram_seq_pkg SHALL hold the state enum, the ERR_COUNT width constant (16) and the pattern function.
REQ-022 The compare/count logic SHALL be one sub-module, bram_seq_checker: tracker, comparator, saturating counter and first-error latch.

Verification (bench: ADDR_WIDTH=4, DATA_WIDTH=8, behavioural one-cycle RAM)
REQ-023 SEED=8'h10, START -> writes 0x10..0x1F to addresses 0..15, DONE at edge 34, PASS=1, ERR_COUNT=0.
REQ-024 RAM forces bit0 of address 5 read data -> ERR_COUNT=1, FIRST_ERR_ADDR=5, PASS=0.
REQ-025 DO_VALID held low for the whole read phase -> ERR_COUNT=16, FIRST_ERR_ADDR=0.
REQ-026 RST pulsed at edge 10 -> all outputs at reset values by edge 11; no DONE; a fresh START then passes.
REQ-027 START held high through the run -> exactly one run; second run begins after FIN; spurious DO_VALID in WRITE -> ERR_COUNT unchanged.
REQ-028 With BRAM_SEQ_INV_PASS_EN and SEED=8'hF8 -> address 15 written 0x07 then 0xF8; DONE at edge 66, PASS=1.
